// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Emits a one-cycle rx_done strobe for each correctly framed byte.
module uart_rx_byte #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int OVS      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int DIV = CLK_FREQ / (BAUD * OVS);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [1:0]    state;
    logic [3:0]    s_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    // Synchronizer resets to the idle level so reset never fakes a start edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (div_cnt == DIV_MAX);

    always_ff @(posedge clk) begin
        if (!reset || state == IDLE) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            s_cnt     <= 4'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    s_cnt   <= 4'd0;
                    bit_cnt <= 3'd0;
                    rx_busy <= 1'b0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    rx_busy <= 1'b1;
                    if (tick) begin
                        if (s_cnt == 4'd7) begin
                            if (rx_s) begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                frame_err <= 1'b0;
                                s_cnt     <= 4'd0;
                                state     <= DATA;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_cnt == 4'd15) begin
                            shreg   <= {rx_s, shreg[7:1]};
                            s_cnt   <= 4'd0;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s_cnt == 4'd15) begin
                            // Leave at mid stop bit so a back-to-back start is caught
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                            if (rx_s) begin
                                rx_data <= shreg;
                                rx_done <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at a fast-sim rate (DIV=2, 32 clocks/bit).
module tb_uart_rx_byte;

    localparam int CLK_FREQ = 320_000;
    localparam int BAUD     = 10_000;
    localparam int BITC     = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    int ferr_cyc = 0;
    logic [7:0] got[$];

    uart_rx_byte #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .OVS     (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && rx_done) begin
            done_cnt = done_cnt + 1;
            got.push_back(rx_data);
        end
        if (rx_busy) busy_cyc = busy_cyc + 1;
        if (frame_err) ferr_cyc = ferr_cyc + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BITC) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data got %h exp 00", rx_data);
        end
        checks++;
        if (rx_done !== 1'b0) begin
            errors++; $display("FAIL reset_done got %b exp 0", rx_done);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b exp 0", rx_busy);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_ferr got %b exp 0", frame_err);
        end
        reset = 1'b1;
        idle(4);
    endtask

    task automatic test_basic;
        int d0, b0, n;
        d0 = done_cnt;
        b0 = busy_cyc;
        send_frame(8'h72, 1'b1);
        idle(40);
        n = done_cnt - d0;
        checks++;
        if (n != 1) begin
            errors++; $display("FAIL basic_pulses got %0d exp 1", n);
        end
        checks++;
        if (got.size() < 1 || got[got.size()-1] !== 8'h72) begin
            errors++; $display("FAIL basic_strobe_data got %0d items exp 72", got.size());
        end
        checks++;
        if (rx_data !== 8'h72) begin
            errors++; $display("FAIL basic_data got %h exp 72", rx_data);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL basic_ferr got %b exp 0", frame_err);
        end
        n = busy_cyc - b0;
        checks++;
        if (n < 300 || n > 306) begin
            errors++; $display("FAIL basic_busy_len got %0d exp 303", n);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++; $display("FAIL basic_busy_end got %b exp 0", rx_busy);
        end
    endtask

    task automatic test_glitch;
        int d0, b0, n;
        d0 = done_cnt;
        b0 = busy_cyc;
        rx = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        idle(2 * BITC);
        n = done_cnt - d0;
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL glitch_pulses got %0d exp 0", n);
        end
        checks++;
        if (rx_data !== 8'h72) begin
            errors++; $display("FAIL glitch_data got %h exp 72", rx_data);
        end
        n = busy_cyc - b0;
        checks++;
        if (n < 12 || n > 18) begin
            errors++; $display("FAIL glitch_busy_len got %0d exp 15", n);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++; $display("FAIL glitch_idle got %b exp 0", rx_busy);
        end
    endtask

    task automatic test_frame_err;
        int d0, n;
        logic [7:0] v;
        d0 = done_cnt;
        send_frame(8'h63, 1'b0);
        idle(2 * BITC);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++; $display("FAIL ferr_set got %b exp 1", frame_err);
        end
        n = done_cnt - d0;
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL ferr_pulses got %0d exp 0", n);
        end
        checks++;
        if (rx_data !== 8'h72) begin
            errors++; $display("FAIL ferr_hold got %h exp 72", rx_data);
        end
        v = 8'h55;
        send_bit(1'b0);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL ferr_clear got %b exp 0", frame_err);
        end
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        send_bit(1'b1);
        idle(40);
        checks++;
        if (rx_data !== 8'h55) begin
            errors++; $display("FAIL ferr_next got %h exp 55", rx_data);
        end
    endtask

    task automatic test_back_to_back;
        int d0, q0, n;
        d0 = done_cnt;
        q0 = got.size();
        send_frame(8'h63, 1'b1);
        send_frame(8'h72, 1'b1);
        idle(40);
        n = done_cnt - d0;
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL b2b_pulses got %0d exp 2", n);
        end
        checks++;
        if (got.size() < q0 + 2 || got[q0] !== 8'h63) begin
            errors++; $display("FAIL b2b_first got %0d items exp 63", got.size() - q0);
        end
        checks++;
        if (got.size() < q0 + 2 || got[q0+1] !== 8'h72) begin
            errors++; $display("FAIL b2b_second got %0d items exp 72", got.size() - q0);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL b2b_ferr got %b exp 0", frame_err);
        end
    endtask

    task automatic test_reset_mid;
        int d0, n;
        logic [7:0] v;
        d0 = done_cnt;
        v = 8'hA5;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(v[i]);
        rx = v[4];
        repeat (BITC / 2) @(posedge clk);
        #1;
        reset = 1'b0;
        rx = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rx_data !== 8'h00 || rx_busy !== 1'b0 || frame_err !== 1'b0 || rx_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outs got %h/%b/%b/%b exp 00/0/0/0",
                     rx_data, rx_busy, frame_err, rx_done);
        end
        reset = 1'b1;
        idle(3 * BITC);
        n = done_cnt - d0;
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL midreset_pulses got %0d exp 0", n);
        end
        send_frame(8'h3C, 1'b1);
        idle(40);
        n = done_cnt - d0;
        checks++;
        if (n != 1 || rx_data !== 8'h3C) begin
            errors++; $display("FAIL midreset_next got %0d/%h exp 1/3c", n, rx_data);
        end
    endtask

    task automatic test_sweep;
        int d0, q0, f0, n;
        d0 = done_cnt;
        q0 = got.size();
        f0 = ferr_cyc;
        for (int v = 0; v < 256; v++) begin
            send_frame(v[7:0], 1'b1);
            idle($urandom_range(0, 4));
        end
        idle(40);
        n = done_cnt - d0;
        checks++;
        if (n != 256) begin
            errors++; $display("FAIL sweep_pulses got %0d exp 256", n);
        end
        n = ferr_cyc - f0;
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL sweep_ferr got %0d exp 0", n);
        end
        for (int v = 0; v < 256; v++) begin
            if (q0 + v < got.size()) begin
                checks++;
                if (got[q0+v] !== v[7:0]) begin
                    errors++;
                    $display("FAIL sweep_byte got %h exp %h", got[q0+v], v[7:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_frame_err;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial UART receiver that turns the board's USB-UART RX pin into 8-bit command bytes for the run/stop/clear control FSM of the up-counter display path. It sits directly upstream of the button/command FSM. It drives that FSM's `i_rx_data` input and adds a one-cycle `rx_done` strobe, so a byte is acted on exactly once. Frame format is fixed 8N1, LSB first, with 16x oversampling and mid-bit sampling.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `OVS`, 16: oversampling factor. Fixed at 16; other values are unsupported.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset. Sampled on the `clk` rising edge; `reset`=0 clears all state.
- `rx`  in  1  asynchronous serial input; idle high.
- `rx_data`  out  8  last correctly framed byte; holds until the next good frame.
- `rx_done`  out  1  one-cycle pulse when `rx_data` updates.
- `rx_busy`  out  1  high while the FSM is not in IDLE.
- `frame_err`  out  1  set when the stop bit is sampled low; cleared at the next start-bit acceptance.

## Operation
- **Input synchronizer:** two-flop chain on `rx`, giving `rx_s`. All decisions use `rx_s` only.
- **Tick generator:**
  - `DIV = CLK_FREQ/(BAUD*OVS)`, integer-truncated (100 MHz / 9600 gives 651).
  - The counter counts 0..DIV-1; `tick` is high for one cycle at DIV-1.
  - The counter is forced to 0 while in IDLE, so bit timing aligns to the detected start edge.
- **State machine** (IDLE, START, DATA, STOP). `s_cnt` is 4 bits; `bit_cnt` is 3 bits.
  - **IDLE:** `s_cnt`=0 and `bit_cnt`=0. When `rx_s`=0, go to START.
  - **START:** on the `tick` with `s_cnt`==7 (mid start bit):
    - if `rx_s`=1, treat it as a glitch and return to IDLE with no output change;
    - otherwise clear `frame_err`, set `s_cnt`=0, go to DATA.
  - **START, other ticks:** `s_cnt`++.
  - **DATA:** on the `tick` with `s_cnt`==15:
    - shift `rx_s` into the MSB of the shift register (right shift, so LSB is received first);
    - set `s_cnt`=0 and increment `bit_cnt`;
    - after the 8th bit (`bit_cnt` was 7), go to STOP.
  - **STOP:** on the `tick` with `s_cnt`==15:
    - if `rx_s`=1, load `rx_data` from the shift register and pulse `rx_done`;
    - if `rx_s`=0, set `frame_err`; `rx_data` keeps its old value and there is no `rx_done`;
    - in both cases, go to IDLE.
  - The FSM returns to IDLE at mid stop bit. The remaining half stop bit is spent in IDLE, so a back-to-back start edge is accepted.
- **Reset values:** `rx_data`=8'h00, `rx_done`=0, `rx_busy`=0, `frame_err`=0. FSM in IDLE, all counters 0, shift register 0.
- **Reset mid-frame:** the partial byte is discarded and no `rx_done` is produced. The receiver resynchronizes on the next falling edge after `reset` returns high. If `rx` is still low, it takes that as a start and validates it at mid-bit as usual.
- **Break condition** (`rx` held low): produces a frame with data 0x00 and `frame_err`=1. The FSM then re-enters START immediately because `rx_s` is still low, and repeats.

## Timing
- **Start detection latency:** 2 clocks (synchronizer) plus 1 clock from the `rx` falling edge to the START state.
- **Mid-bit offsets** after entering START:
  - start-bit check at 8·DIV clocks;
  - data bit n sampled at (8 + 16·(n+1))·DIV clocks;
  - stop bit sampled at (8 + 16·9)·DIV = 152·DIV clocks.
- **`rx_done` pulse:** exactly one clock wide. It is asserted in the cycle after the stop-bit sample edge, and `rx_data` is valid in that same cycle.
- **`rx_busy`:** asserts 1 clock after START is entered; deasserts in the same cycle as `rx_done`/`frame_err` update.
- **Baud error:** truncation error must stay below 2%. 100 MHz at 9600 gives +0.006%.

## Test plan
- Reset, then send 0x72 ('r') at 9600 baud → `rx_data`=0x72, one `rx_done` pulse, `frame_err`=0, `rx_busy` high for about 152·651 clocks.
- `rx` low pulse of 2000 clocks (less than half a bit, 5208 clocks), then idle → back in IDLE after the mid-start check; no `rx_done`; `rx_data` unchanged.
- Send 0x63 with the stop bit forced low → `frame_err`=1, no `rx_done`, `rx_data` keeps the prior 0x72. Then send a good 0x55 → `frame_err` clears at its start check and `rx_data`=0x55.
- Send 0x63 then 0x72 back-to-back, one stop bit each with no idle gap → exactly two `rx_done` pulses with data 0x63 then 0x72.
- Drive `reset`=0 for 1 clock after the 4th data bit of 0xA5 → all outputs return to reset values and no `rx_done`. Then send 0x3C → received correctly.
- Fast-sim override `CLK_FREQ`=1_600_000, `BAUD`=10_000 (DIV=10). Sweep all 256 byte values with a randomized inter-frame gap of 0–40 bits → every byte matches, with 256 `rx_done` pulses and no `frame_err`.
